// File: rtl/noc_local_ni_if.sv
// Core-side injection/ejection handshake bundle of the Phoenix local network interface.
interface noc_local_ni_if #(
  parameter int unsigned TAM_FLIT = 16
);
  logic                inj_valid;
  logic [TAM_FLIT-1:0] inj_data;
  logic                inj_ready;
  logic                ej_valid;
  logic [TAM_FLIT-1:0] ej_data;
  logic                ej_first;
  logic                ej_last;
  logic                ej_ready;

  // Core / agent side
  modport master (
    output inj_valid, inj_data, ej_ready,
    input  inj_ready, ej_valid, ej_data, ej_first, ej_last
  );

  // Network-interface side
  modport slave (
    input  inj_valid, inj_data, ej_ready,
    output inj_ready, ej_valid, ej_data, ej_first, ej_last
  );
endinterface

// File: rtl/noc_local_ni.sv
// Local-port network interface for the Phoenix mesh: injection FIFO with packet
// framing under credit flow control toward the router, ejection FIFO with
// first/last tags from the router, and wrap-around packet counters.
// Optional destination check on received headers: define NI_DEST_CHECK_EN.
module noc_local_ni #(
  parameter int unsigned         TAM_FLIT  = 16,
  parameter logic [TAM_FLIT-1:0] ADDRESS   = '0,
  parameter int unsigned         INJ_DEPTH = 8,
  parameter int unsigned         EJ_DEPTH  = 8,
  parameter int unsigned         CNT_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  noc_local_ni_if.slave       core,
  output logic                tx_o,
  output logic [TAM_FLIT-1:0] data_o,
  output logic                clock_tx_o,
  input  logic                credit_i,
  input  logic                rx_i,
  input  logic [TAM_FLIT-1:0] data_i,
  output logic                credit_o,
  output logic [CNT_W-1:0]    pkt_tx_cnt,
  output logic [CNT_W-1:0]    pkt_rx_cnt
`ifdef NI_DEST_CHECK_EN
  ,
  output logic [CNT_W-1:0]    misroute_cnt,
  output logic                err_misroute
`endif
);

  localparam int unsigned INJ_AW = $clog2(INJ_DEPTH);
  localparam int unsigned INJ_CW = INJ_AW + 1;
  localparam int unsigned EJ_AW  = $clog2(EJ_DEPTH);
  localparam int unsigned EJ_CW  = EJ_AW + 1;

  typedef enum logic [1:0] {T_HDR, T_SIZE, T_PAY} tx_state_e;
  typedef enum logic [1:0] {R_HDR, R_SIZE, R_PAY} rx_state_e;

  // ---------------- injection path ----------------
  logic [TAM_FLIT-1:0] inj_mem_q [INJ_DEPTH];
  logic [INJ_AW-1:0]   inj_wr_q, inj_rd_q;
  logic [INJ_CW-1:0]   inj_cnt_q;
  logic                inj_full, inj_empty, inj_push, inj_pop;
  tx_state_e           t_state_q;
  logic [TAM_FLIT-1:0] rem_q;

  assign inj_full       = (inj_cnt_q == INJ_CW'(INJ_DEPTH));
  assign inj_empty      = (inj_cnt_q == '0);
  assign inj_push       = core.inj_valid && !inj_full;
  assign inj_pop        = !inj_empty && credit_i;
  assign core.inj_ready = !inj_full;
  assign tx_o           = !inj_empty;
  assign data_o         = inj_empty ? '0 : inj_mem_q[inj_rd_q];
  assign clock_tx_o     = clock;

  // Injection storage; contents are don't-care while the slot is free
  always_ff @(posedge clock) begin
    if (inj_push) inj_mem_q[inj_wr_q] <= core.inj_data;
  end

  // Injection pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      inj_wr_q  <= '0;
      inj_rd_q  <= '0;
      inj_cnt_q <= '0;
    end else begin
      if (inj_push) inj_wr_q <= inj_wr_q + INJ_AW'(1);
      if (inj_pop)  inj_rd_q <= inj_rd_q + INJ_AW'(1);
      case ({inj_push, inj_pop})
        2'b10:   inj_cnt_q <= inj_cnt_q + INJ_CW'(1);
        2'b01:   inj_cnt_q <= inj_cnt_q - INJ_CW'(1);
        default: inj_cnt_q <= inj_cnt_q;
      endcase
    end
  end

  // Transmit framing: tracks header/size/payload and counts completed packets
  always_ff @(posedge clock) begin
    if (reset) begin
      t_state_q  <= T_HDR;
      rem_q      <= '0;
      pkt_tx_cnt <= '0;
    end else if (inj_pop) begin
      case (t_state_q)
        T_HDR: t_state_q <= T_SIZE;
        T_SIZE: begin
          rem_q <= data_o;
          if (data_o != '0) begin
            t_state_q <= T_PAY;
          end else begin
            t_state_q  <= T_HDR;
            pkt_tx_cnt <= pkt_tx_cnt + CNT_W'(1);
          end
        end
        T_PAY: begin
          rem_q <= rem_q - TAM_FLIT'(1);
          if (rem_q == TAM_FLIT'(1)) begin
            t_state_q  <= T_HDR;
            pkt_tx_cnt <= pkt_tx_cnt + CNT_W'(1);
          end
        end
        default: t_state_q <= T_HDR;
      endcase
    end
  end

  // ---------------- ejection path ----------------
  logic [TAM_FLIT-1:0] ej_mem_q [EJ_DEPTH];
  logic [1:0]          ej_tag_q [EJ_DEPTH];
  logic [EJ_AW-1:0]    ej_wr_q, ej_rd_q;
  logic [EJ_CW-1:0]    ej_cnt_q;
  logic                ej_full, ej_empty, ej_wr, ej_pop;
  logic                wr_first_c, wr_last_c;
  rx_state_e           r_state_q;
  logic [TAM_FLIT-1:0] rrem_q;

  assign ej_full       = (ej_cnt_q == EJ_CW'(EJ_DEPTH));
  assign ej_empty      = (ej_cnt_q == '0);
  assign credit_o      = !ej_full;
  assign ej_wr         = rx_i && !ej_full;
  assign ej_pop        = !ej_empty && core.ej_ready;
  assign core.ej_valid = !ej_empty;
  assign core.ej_data  = ej_empty ? '0 : ej_mem_q[ej_rd_q];
  assign core.ej_first = !ej_empty && ej_tag_q[ej_rd_q][1];
  assign core.ej_last  = !ej_empty && ej_tag_q[ej_rd_q][0];

  // Packet-boundary tags for the flit being written
  always_comb begin
    wr_first_c = 1'b0;
    wr_last_c  = 1'b0;
    case (r_state_q)
      R_HDR:   wr_first_c = 1'b1;
      R_SIZE:  wr_last_c  = (data_i == '0);
      R_PAY:   wr_last_c  = (rrem_q == TAM_FLIT'(1));
      default: wr_first_c = 1'b0;
    endcase
  end

  // Ejection storage with {first,last} tags
  always_ff @(posedge clock) begin
    if (ej_wr) begin
      ej_mem_q[ej_wr_q] <= data_i;
      ej_tag_q[ej_wr_q] <= {wr_first_c, wr_last_c};
    end
  end

  // Ejection pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      ej_wr_q  <= '0;
      ej_rd_q  <= '0;
      ej_cnt_q <= '0;
    end else begin
      if (ej_wr)  ej_wr_q <= ej_wr_q + EJ_AW'(1);
      if (ej_pop) ej_rd_q <= ej_rd_q + EJ_AW'(1);
      case ({ej_wr, ej_pop})
        2'b10:   ej_cnt_q <= ej_cnt_q + EJ_CW'(1);
        2'b01:   ej_cnt_q <= ej_cnt_q - EJ_CW'(1);
        default: ej_cnt_q <= ej_cnt_q;
      endcase
    end
  end

  // Receive framing on the write side, packet count and optional header check
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state_q    <= R_HDR;
      rrem_q       <= '0;
      pkt_rx_cnt   <= '0;
`ifdef NI_DEST_CHECK_EN
      misroute_cnt <= '0;
      err_misroute <= 1'b0;
`endif
    end else if (ej_wr) begin
      if (wr_last_c) pkt_rx_cnt <= pkt_rx_cnt + CNT_W'(1);
      case (r_state_q)
        R_HDR: begin
          r_state_q <= R_SIZE;
`ifdef NI_DEST_CHECK_EN
          if (data_i != ADDRESS) begin
            misroute_cnt <= misroute_cnt + CNT_W'(1);
            err_misroute <= 1'b1;
          end
`endif
        end
        R_SIZE: begin
          rrem_q    <= data_i;
          r_state_q <= (data_i != '0) ? R_PAY : R_HDR;
        end
        R_PAY: begin
          rrem_q <= rrem_q - TAM_FLIT'(1);
          if (rrem_q == TAM_FLIT'(1)) r_state_q <= R_HDR;
        end
        default: r_state_q <= R_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: hand-derived vector table, corner-case sequences and
// randomized traffic against a queue-based packet model.
module tb_noc_local_ni;
  localparam int          TF    = 16;
  localparam int          DEPTH = 8;
  localparam int          CW    = 4;
  localparam logic [15:0] ADDR  = 16'h0101;
  localparam logic        H = 1'b1;
  localparam logic        L = 1'b0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, tx_o, clock_tx_o, credit_i, rx_i, credit_o;
  logic [15:0]   data_o, data_i;
  logic [CW-1:0] pkt_tx_cnt, pkt_rx_cnt;
`ifdef NI_DEST_CHECK_EN
  logic [CW-1:0] misroute_cnt;
  logic          err_misroute;
`endif

  noc_local_ni_if #(.TAM_FLIT(TF)) core_if ();

  noc_local_ni #(
    .TAM_FLIT(TF), .ADDRESS(ADDR), .INJ_DEPTH(DEPTH), .EJ_DEPTH(DEPTH), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset), .core(core_if),
    .tx_o(tx_o), .data_o(data_o), .clock_tx_o(clock_tx_o), .credit_i(credit_i),
    .rx_i(rx_i), .data_i(data_i), .credit_o(credit_o),
    .pkt_tx_cnt(pkt_tx_cnt), .pkt_rx_cnt(pkt_rx_cnt)
`ifdef NI_DEST_CHECK_EN
    , .misroute_cnt(misroute_cnt), .err_misroute(err_misroute)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (packet-position arithmetic on queues) ----------------
  typedef struct packed { logic [15:0] d; logic f; logic l; } ej_ent_t;
  logic [15:0] m_inj[$];
  ej_ent_t     m_ej[$];
  int m_tx_pos = 0, m_tx_len = 0, m_rx_pos = 0, m_rx_len = 0;
  int m_tx_pkts = 0, m_rx_pkts = 0, m_mis = 0;
  bit m_err = 0, m_pushed = 0, m_wrote = 0;

  task automatic model_step();
    logic [15:0] f;
    ej_ent_t e;
    bit push, xfer, wr, pop;
    m_pushed = 0;
    m_wrote  = 0;
    if (reset) begin
      m_inj.delete(); m_ej.delete();
      m_tx_pos = 0; m_rx_pos = 0; m_tx_pkts = 0; m_rx_pkts = 0; m_mis = 0; m_err = 0;
      return;
    end
    push = core_if.inj_valid && (m_inj.size() < DEPTH);
    xfer = (m_inj.size() > 0) && credit_i;
    if (xfer) begin
      f = m_inj.pop_front();
      if (m_tx_pos == 1) m_tx_len = int'(f) + 2;
      if (m_tx_pos >= 1 && m_tx_pos == m_tx_len - 1) begin
        m_tx_pkts++;
        m_tx_pos = 0;
      end else m_tx_pos++;
    end
    if (push) begin
      m_inj.push_back(core_if.inj_data);
      m_pushed = 1;
    end
    wr  = rx_i && (m_ej.size() < DEPTH);
    pop = (m_ej.size() > 0) && core_if.ej_ready;
    if (pop) void'(m_ej.pop_front());
    if (wr) begin
      e.d = data_i;
      e.f = (m_rx_pos == 0);
      if (m_rx_pos == 0 && data_i != ADDR) begin
        m_mis++;
        m_err = 1;
      end
      if (m_rx_pos == 1) m_rx_len = int'(data_i) + 2;
      e.l = (m_rx_pos >= 1 && m_rx_pos == m_rx_len - 1);
      if (e.l) begin
        m_rx_pkts++;
        m_rx_pos = 0;
      end else m_rx_pos++;
      m_ej.push_back(e);
      m_wrote = 1;
    end
  endtask

  task automatic compare_model();
    ej_ent_t e;
    e = (m_ej.size() > 0) ? m_ej[0] : '0;
    chk("m_inj_ready",  core_if.inj_ready, m_inj.size() < DEPTH);
    chk("m_tx_o",       tx_o, m_inj.size() > 0);
    chk("m_data_o",     data_o, (m_inj.size() > 0) ? m_inj[0] : 16'h0);
    chk("m_credit_o",   credit_o, m_ej.size() < DEPTH);
    chk("m_ej_valid",   core_if.ej_valid, m_ej.size() > 0);
    chk("m_ej_data",    core_if.ej_data, e.d);
    chk("m_ej_first",   core_if.ej_first, e.f);
    chk("m_ej_last",    core_if.ej_last, e.l);
    chk("m_pkt_tx_cnt", pkt_tx_cnt, m_tx_pkts % (1 << CW));
    chk("m_pkt_rx_cnt", pkt_rx_cnt, m_rx_pkts % (1 << CW));
`ifdef NI_DEST_CHECK_EN
    chk("m_misroute_cnt", misroute_cnt, m_mis % (1 << CW));
    chk("m_err_misroute", err_misroute, m_err);
`endif
  endtask

  // One clock: inputs already driven; model and compare at the falling edge
  task automatic cycle();
    @(negedge clock);
    model_step();
    compare_model();
  endtask

  task automatic set_in(input logic rst, iv, input logic [15:0] id, input logic cr, rx,
                        input logic [15:0] di, input logic er);
    reset = rst; core_if.inj_valid = iv; core_if.inj_data = id;
    credit_i = cr; rx_i = rx; data_i = di; core_if.ej_ready = er;
  endtask

  task automatic do_reset();
    set_in(H, L, 16'h0, H, L, 16'h0, L);
    cycle();
    reset = L;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, iv; logic [15:0] id; logic cr, rx; logic [15:0] di; logic er;
    logic irdy, tx; logic [15:0] dout; logic cro, ejv; logic [15:0] ejd; logic ejf, ejl;
    int txc, rxc;
  } vec_t;

  function automatic vec_t v(input logic rst, iv, input logic [15:0] id, input logic cr, rx,
                             input logic [15:0] di, input logic er, input logic irdy, tx,
                             input logic [15:0] dout, input logic cro, ejv,
                             input logic [15:0] ejd, input logic ejf, ejl, input int txc, rxc);
    vec_t r;
    r.rst = rst; r.iv = iv; r.id = id; r.cr = cr; r.rx = rx; r.di = di; r.er = er;
    r.irdy = irdy; r.tx = tx; r.dout = dout; r.cro = cro; r.ejv = ejv; r.ejd = ejd;
    r.ejf = ejf; r.ejl = ejl; r.txc = txc; r.rxc = rxc;
    return r;
  endfunction

  typedef logic [15:0] fq_t[$];
  function automatic fq_t gen_pkt(input bit for_rx);
    fq_t q;
    int sz;
    sz = $urandom_range(0, 5);
    if (for_rx && $urandom_range(0, 1) == 0) q.push_back(ADDR);
    else q.push_back(16'($urandom));
    q.push_back(16'(sz));
    for (int k = 0; k < sz; k++) q.push_back(16'($urandom));
    return q;
  endfunction

  localparam int NV = 20;
  vec_t vt[NV];
  fq_t tx_gen, rx_gen;

  initial begin
    //            rst iv id        cr rx di        er | irdy tx dout    cro ejv ejd       f  l  txc rxc
    vt[0]  = v(H, L, 16'h0000, H, L, 16'h0000, L,  H, L, 16'h0000, H, L, 16'h0000, L, L, 0, 0);
    vt[1]  = v(L, H, 16'h0102, H, L, 16'h0000, L,  H, H, 16'h0102, H, L, 16'h0000, L, L, 0, 0);
    vt[2]  = v(L, H, 16'h0003, H, L, 16'h0000, L,  H, H, 16'h0003, H, L, 16'h0000, L, L, 0, 0);
    vt[3]  = v(L, H, 16'h00A1, H, L, 16'h0000, L,  H, H, 16'h00A1, H, L, 16'h0000, L, L, 0, 0);
    vt[4]  = v(L, H, 16'h00A2, H, L, 16'h0000, L,  H, H, 16'h00A2, H, L, 16'h0000, L, L, 0, 0);
    vt[5]  = v(L, H, 16'h00A3, H, L, 16'h0000, L,  H, H, 16'h00A3, H, L, 16'h0000, L, L, 0, 0);
    vt[6]  = v(L, L, 16'h0000, H, L, 16'h0000, L,  H, L, 16'h0000, H, L, 16'h0000, L, L, 1, 0);
    vt[7]  = v(L, L, 16'h0000, H, H, 16'h0000, L,  H, L, 16'h0000, H, H, 16'h0000, H, L, 1, 0);
    vt[8]  = v(L, L, 16'h0000, H, H, 16'h0002, L,  H, L, 16'h0000, H, H, 16'h0000, H, L, 1, 0);
    vt[9]  = v(L, L, 16'h0000, H, H, 16'h00B1, L,  H, L, 16'h0000, H, H, 16'h0000, H, L, 1, 0);
    vt[10] = v(L, L, 16'h0000, H, H, 16'h00B2, L,  H, L, 16'h0000, H, H, 16'h0000, H, L, 1, 1);
    vt[11] = v(L, L, 16'h0000, H, H, 16'h0101, L,  H, L, 16'h0000, H, H, 16'h0000, H, L, 1, 1);
    vt[12] = v(L, L, 16'h0000, H, H, 16'h0000, L,  H, L, 16'h0000, H, H, 16'h0000, H, L, 1, 2);
    vt[13] = v(L, L, 16'h0000, H, H, 16'h0101, L,  H, L, 16'h0000, H, H, 16'h0000, H, L, 1, 2);
    vt[14] = v(L, L, 16'h0000, H, H, 16'h0001, L,  H, L, 16'h0000, L, H, 16'h0000, H, L, 1, 2);
    vt[15] = v(L, L, 16'h0000, H, H, 16'h00C1, H,  H, L, 16'h0000, H, H, 16'h0002, L, L, 1, 2);
    vt[16] = v(L, L, 16'h0000, H, H, 16'h00C2, H,  H, L, 16'h0000, H, H, 16'h00B1, L, L, 1, 3);
    vt[17] = v(L, L, 16'h0000, H, L, 16'h0000, H,  H, L, 16'h0000, H, H, 16'h00B2, L, H, 1, 3);
    vt[18] = v(L, L, 16'h0000, H, L, 16'h0000, H,  H, L, 16'h0000, H, H, 16'h0101, H, L, 1, 3);
    vt[19] = v(L, L, 16'h0000, H, L, 16'h0000, H,  H, L, 16'h0000, H, H, 16'h0000, L, H, 1, 3);

    for (int i = 0; i < NV; i++) begin
      set_in(vt[i].rst, vt[i].iv, vt[i].id, vt[i].cr, vt[i].rx, vt[i].di, vt[i].er);
      cycle();
      chk($sformatf("v%0d_inj_ready", i), core_if.inj_ready, vt[i].irdy);
      chk($sformatf("v%0d_tx_o", i), tx_o, vt[i].tx);
      chk($sformatf("v%0d_data_o", i), data_o, vt[i].dout);
      chk($sformatf("v%0d_credit_o", i), credit_o, vt[i].cro);
      chk($sformatf("v%0d_ej_valid", i), core_if.ej_valid, vt[i].ejv);
      chk($sformatf("v%0d_ej_data", i), core_if.ej_data, vt[i].ejd);
      chk($sformatf("v%0d_ej_first", i), core_if.ej_first, vt[i].ejf);
      chk($sformatf("v%0d_ej_last", i), core_if.ej_last, vt[i].ejl);
      chk($sformatf("v%0d_pkt_tx_cnt", i), pkt_tx_cnt, vt[i].txc);
      chk($sformatf("v%0d_pkt_rx_cnt", i), pkt_rx_cnt, vt[i].rxc);
    end

    // Backpressure: 9 offers with no credit, then drain
    do_reset();
    credit_i = L;
    core_if.ej_ready = H;
    for (int i = 0; i < 9; i++) begin
      core_if.inj_valid = H;
      core_if.inj_data  = (i == 0) ? 16'h0001 : (i == 1) ? 16'h0006 : 16'(16'h00D0 + i);
      cycle();
      if (i == 6) chk("bp_ready_before_full", core_if.inj_ready, 1);
      if (i >= 7) chk("bp_ready_low", core_if.inj_ready, 0);
      chk("bp_data_hold", data_o, 16'h0001);
      chk("bp_tx_hold", tx_o, 1);
    end
    core_if.inj_valid = L;
    credit_i = H;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("bp_ready_back", core_if.inj_ready, 1);
    end
    chk("bp_drained", tx_o, 0);
    chk("bp_pkt_cnt", pkt_tx_cnt, 1);

    // Zero-size packets and counter wrap
    do_reset();
    for (int p = 0; p < 17; p++) begin
      for (int k = 0; k < 2; k++) begin
        core_if.inj_valid = H;
        core_if.inj_data  = (k == 0) ? 16'(16'h0200 + p) : 16'h0000;
        cycle();
        if (p == 0 && k == 1) chk("zs_first_hdr_sent", pkt_tx_cnt, 0);
      end
      if (p == 0) begin
        core_if.inj_valid = L;
        cycle();
        chk("zs_one_pkt", pkt_tx_cnt, 1);
        chk("zs_empty", tx_o, 0);
      end
    end
    core_if.inj_valid = L;
    for (int i = 0; i < 3; i++) cycle();
    chk("wrap_pkt_cnt", pkt_tx_cnt, 1);

    // Reset in the middle of a packet
    do_reset();
    credit_i = L;
    core_if.ej_ready = L;
    for (int i = 0; i < 4; i++) begin
      core_if.inj_valid = H;
      core_if.inj_data  = (i == 0) ? 16'h0009 : (i == 1) ? 16'h0004 : 16'(16'h00E0 + i);
      rx_i = (i < 2);
      data_i = (i == 0) ? ADDR : 16'h0000;
      cycle();
    end
    core_if.inj_valid = L;
    rx_i = L;
    credit_i = H;
    for (int i = 0; i < 3; i++) cycle();
    chk("mr_rx_cnt_pre", pkt_rx_cnt, 1);
    reset = H;
    cycle();
    reset = L;
    chk("mr_tx_o", tx_o, 0);
    chk("mr_ej_valid", core_if.ej_valid, 0);
    chk("mr_tx_cnt", pkt_tx_cnt, 0);
    chk("mr_rx_cnt", pkt_rx_cnt, 0);
    core_if.inj_valid = H; core_if.inj_data = 16'h0001; cycle();
    core_if.inj_data = 16'h0000; cycle();
    core_if.inj_valid = L; cycle();
    chk("mr_new_hdr_pkt", pkt_tx_cnt, 1);

`ifdef NI_DEST_CHECK_EN
    // Header destination check
    do_reset();
    core_if.ej_ready = H;
    rx_i = H; data_i = 16'h0202; cycle();
    data_i = 16'h0000; cycle();
    rx_i = L; cycle();
    chk("dc_err", err_misroute, 1);
    chk("dc_cnt", misroute_cnt, 1);
    chk("dc_delivered", pkt_rx_cnt, 1);
    rx_i = H; data_i = ADDR; cycle();
    data_i = 16'h0000; cycle();
    rx_i = L; cycle();
    chk("dc_err_hold", err_misroute, 1);
    chk("dc_cnt_hold", misroute_cnt, 1);
    chk("dc_delivered2", pkt_rx_cnt, 2);
`endif

    // Randomized traffic against the model
    do_reset();
    tx_gen.delete();
    rx_gen.delete();
    for (int c = 0; c < 3000; c++) begin
      if (tx_gen.size() == 0) tx_gen = gen_pkt(1'b0);
      if (rx_gen.size() == 0) rx_gen = gen_pkt(1'b1);
      core_if.inj_valid = ($urandom_range(0, 3) != 0);
      core_if.inj_data  = tx_gen[0];
      credit_i          = ($urandom_range(0, 3) != 0);
      rx_i              = ($urandom_range(0, 2) != 0);
      data_i            = rx_gen[0];
      core_if.ej_ready  = ($urandom_range(0, 2) != 0);
      reset             = ($urandom_range(0, 299) == 0);
      cycle();
      if (reset) begin
        tx_gen.delete();
        rx_gen.delete();
      end else begin
        if (m_pushed) void'(tx_gen.pop_front());
        if (m_wrote)  void'(rx_gen.pop_front());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
